// File: rtl/idex_hazard_stage_pkg.sv
// Shared types for the ID/EX hazard stage: FSM state encoding, XZR index, EX control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package idex_hazard_stage_pkg;

    // Stage FSM. STALL marks the single bubble cycle of a load-use interlock,
    // FLUSH marks the cycle after a taken branch (Branching is high there).
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    // XZR: reads as zero and discards writes, so it can never carry a dependency.
    localparam int unsigned ZERO_REG_IDX = 31;

    // Control bits that must be cleared for an EX bubble.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{
        valid:     1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        branch:    1'b0
    };

endpackage

// File: rtl/idex_hazard_stage_if.sv
// Bundle of ID-side inputs and EX-side/stall outputs of the ID/EX hazard stage.
// Latency: n/a (wiring only).
// Backpressure: pc_write/ifid_write low = hold PC and IF/ID.
// Ports: slave = stage side (consumes id_*, branch_taken; drives ex_*, IDEX_*, Branching,
//        pc_write, ifid_write, counters); master = pipeline/testbench side.
interface idex_hazard_stage_if #(
    parameter int DATA_W  = 64,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
);
    // ID side
    logic               id_valid;
    logic [REG_W-1:0]   id_rm;
    logic [REG_W-1:0]   id_rn;
    logic [REG_W-1:0]   id_rd;
    logic               id_uses_rm;
    logic               id_uses_rn;
    logic               id_reg_write;
    logic               id_mem_read;
    logic               id_mem_write;
    logic               id_branch;
    logic [ALUOP_W-1:0] id_alu_op;
    logic [DATA_W-1:0]  id_rm_data;
    logic [DATA_W-1:0]  id_rn_data;
    logic [DATA_W-1:0]  id_imm;
    logic               branch_taken;

    // EX side
    logic               ex_valid;
    logic [REG_W-1:0]   IDEX_rm;
    logic [REG_W-1:0]   IDEX_rn;
    logic [REG_W-1:0]   IDEX_rd;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic               ex_branch;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic [DATA_W-1:0]  ex_rm_data;
    logic [DATA_W-1:0]  ex_rn_data;
    logic [DATA_W-1:0]  ex_imm;
    logic               Branching;

    // Stall controls and debug counters
    logic               pc_write;
    logic               ifid_write;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport slave (
        input  id_valid, id_rm, id_rn, id_rd, id_uses_rm, id_uses_rn,
               id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_op,
               id_rm_data, id_rn_data, id_imm, branch_taken,
        output ex_valid, IDEX_rm, IDEX_rn, IDEX_rd, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_branch, ex_alu_op, ex_rm_data, ex_rn_data, ex_imm,
               Branching, pc_write, ifid_write, stall_cnt, flush_cnt
    );

    modport master (
        output id_valid, id_rm, id_rn, id_rd, id_uses_rm, id_uses_rn,
               id_reg_write, id_mem_read, id_mem_write, id_branch, id_alu_op,
               id_rm_data, id_rn_data, id_imm, branch_taken,
        input  ex_valid, IDEX_rm, IDEX_rn, IDEX_rd, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_branch, ex_alu_op, ex_rm_data, ex_rn_data, ex_imm,
               Branching, pc_write, ifid_write, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/idex_hazard_stage_hazard_detect.sv
// Load-use compare: a load in EX whose destination is read by the instruction in ID.
// Latency: combinational.
// Backpressure: none; result feeds the stage's stall decision.
// Ports: i_ex_* = EX-stage load info, i_id_* = ID sources, o_hazard = interlock request.
module idex_hazard_stage_hazard_detect #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_reg_write,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rm,
    input  logic [REG_W-1:0] i_id_rn,
    input  logic             i_id_uses_rm,
    input  logic             i_id_uses_rn,
    output logic             o_hazard
);

    logic w_ex_is_load;
    logic w_rm_hit;
    logic w_rn_hit;

    // A load targeting XZR produces nothing a consumer could wait on.
    assign w_ex_is_load = i_ex_valid && i_ex_mem_read && i_ex_reg_write &&
                          (i_ex_rd != REG_W'(ZERO_REG));

    // Only sources the instruction actually reads count; unused fields may hold junk.
    assign w_rm_hit = i_id_uses_rm && (i_id_rm == i_ex_rd);
    assign w_rn_hit = i_id_uses_rn && (i_id_rn == i_ex_rd);

    assign o_hazard = w_ex_is_load && i_id_valid && (w_rm_hit || w_rn_hit);

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use interlock, branch squash and bubble counters.
// Latency: 1 cycle ID->EX; a load-use hit costs exactly one bubble.
// Backpressure: pc_write/ifid_write drop (combinationally) for the stall cycle; a taken branch wins.
// Ports: clk, rst_n (async active-low); bus = idex_hazard_stage_if.slave with ID inputs,
//        registered EX outputs, Branching, pc_write/ifid_write, stall_cnt/flush_cnt.
module idex_hazard_stage
    import idex_hazard_stage_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 4,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = ZERO_REG_IDX
) (
    input  logic           clk,
    input  logic           rst_n,
    idex_hazard_stage_if.slave bus
);

    typedef struct packed {
        ex_ctrl_t           ctrl;
        logic [ALUOP_W-1:0] alu_op;
        logic [REG_W-1:0]   rm;
        logic [REG_W-1:0]   rn;
        logic [REG_W-1:0]   rd;
        logic [DATA_W-1:0]  rm_data;
        logic [DATA_W-1:0]  rn_data;
        logic [DATA_W-1:0]  imm;
    } ex_stage_t;

    state_e           r_state;
    ex_stage_t        r_ex;
    logic             r_branching;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    ex_stage_t w_id;
    ex_stage_t w_ex_nxt;
    logic      w_hazard;
    logic      w_flush;
    logic      w_stall;

    idex_hazard_stage_hazard_detect #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG)
    ) u_hazard_detect (
        .i_ex_valid     (r_ex.ctrl.valid),
        .i_ex_mem_read  (r_ex.ctrl.mem_read),
        .i_ex_reg_write (r_ex.ctrl.reg_write),
        .i_ex_rd        (r_ex.rd),
        .i_id_valid     (bus.id_valid),
        .i_id_rm        (bus.id_rm),
        .i_id_rn        (bus.id_rn),
        .i_id_uses_rm   (bus.id_uses_rm),
        .i_id_uses_rn   (bus.id_uses_rn),
        .o_hazard       (w_hazard)
    );

    always_comb begin
        w_id                = '0;
        w_id.ctrl.valid     = bus.id_valid;
        w_id.ctrl.reg_write = bus.id_reg_write;
        w_id.ctrl.mem_read  = bus.id_mem_read;
        w_id.ctrl.mem_write = bus.id_mem_write;
        w_id.ctrl.branch    = bus.id_branch;
        w_id.alu_op         = bus.id_alu_op;
        w_id.rm             = bus.id_rm;
        w_id.rn             = bus.id_rn;
        w_id.rd             = bus.id_rd;
        w_id.rm_data        = bus.id_rm_data;
        w_id.rn_data        = bus.id_rn_data;
        w_id.imm            = bus.id_imm;
    end

    // The taken branch squashes whatever sits in ID, so it overrides the interlock.
    // In STALL the EX slot already holds a bubble, so no hazard can be pending there.
    assign w_flush = bus.branch_taken;
    assign w_stall = w_hazard && !w_flush && (r_state != ST_STALL);

    always_comb begin
        w_ex_nxt = w_id;
        if (w_flush || w_stall) begin
            w_ex_nxt      = '0;
            w_ex_nxt.ctrl = BUBBLE_CTRL;
        end
    end

    // FSM, EX register, Branching flag and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_ex        <= '0;
            r_branching <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_ex <= w_ex_nxt;

            case (r_state)
                ST_RUN, ST_FLUSH: begin
                    if (w_flush) begin
                        r_state <= ST_FLUSH;
                    end else if (w_stall) begin
                        r_state <= ST_STALL;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_STALL: begin
                    r_state <= w_flush ? ST_FLUSH : ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase

            // Registered so it is high exactly during the FLUSH cycle.
            r_branching <= w_flush;

            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ex_valid     = r_ex.ctrl.valid;
    assign bus.ex_reg_write = r_ex.ctrl.reg_write;
    assign bus.ex_mem_read  = r_ex.ctrl.mem_read;
    assign bus.ex_mem_write = r_ex.ctrl.mem_write;
    assign bus.ex_branch    = r_ex.ctrl.branch;
    assign bus.ex_alu_op    = r_ex.alu_op;
    assign bus.IDEX_rm      = r_ex.rm;
    assign bus.IDEX_rn      = r_ex.rn;
    assign bus.IDEX_rd      = r_ex.rd;
    assign bus.ex_rm_data   = r_ex.rm_data;
    assign bus.ex_rn_data   = r_ex.rn_data;
    assign bus.ex_imm       = r_ex.imm;
    assign bus.Branching    = r_branching;
    assign bus.pc_write     = !w_stall;
    assign bus.ifid_write   = !w_stall;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;

endmodule
